// File: rtl/lsu_responder.sv
// -----------------------------------------------------------------------------
// lsu_responder
//
// Responder side of the MEM-stage LSU VALID/READY handshake. A request held on
// i_lsu_* is captured once, sized/aligned/byte-enabled, and issued on a
// req/gnt/rvalid data-memory bus. Load data is lane-extracted and sign/zero
// extended, then returned with a single-cycle READY pulse together with the
// fault flags.
//
// Optional feature (compile-time macro): LSU_TIMEOUT_EN
//   Aborts a bus request that has waited TIMEOUT_CYCLES cycles in REQ without
//   i_mem_gnt and reports it through o_lsu_timeout. Without the macro REQ waits
//   indefinitely and o_lsu_timeout is always 0.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_lsu_VALID         request valid, held with stable fields until READY
//   i_lsu_we            1 = store, 0 = load
//   i_lsu_funct3        RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   i_lsu_addr          byte address
//   i_lsu_wdata         right-aligned store data
//   o_lsu_READY         one-cycle completion pulse
//   o_lsu_rdata         extended load result (0 for stores/faults), with READY
//   o_lsu_misaligned    misaligned-access fault, with READY
//   o_lsu_timeout       bus-timeout fault, with READY
//   o_mem_req/we/addr/be/wdata   bus request; addr is word aligned
//   i_mem_gnt           request accepted
//   i_mem_rvalid        response (load data or store ack)
//   i_mem_rdata         load word
// -----------------------------------------------------------------------------
module lsu_responder #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_VALID,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_READY,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_misaligned,
  output logic        o_lsu_timeout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;

  // Captured request, already converted to bus form.
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  // Response registers, only visible while READY is high.
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic        timeout_q;

  // ---------------------------------------------------------------------------
  // Request decode (combinational on the incoming request)
  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the unused 011/110/111).
  // ---------------------------------------------------------------------------
  logic        is_byte, is_half;
  logic        misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    is_byte       = (i_lsu_funct3[1:0] == 2'b00);
    is_half       = (i_lsu_funct3[1:0] == 2'b01);
    misaligned_in = (is_half && i_lsu_addr[0]) ||
                    (!is_byte && !is_half && (i_lsu_addr[1:0] != 2'b00));
    if (is_byte) begin
      be_in    = 4'b0001 << i_lsu_addr[1:0];
      wdata_in = {4{i_lsu_wdata[7:0]}};
    end else if (is_half) begin
      be_in    = 4'b0011 << i_lsu_addr[1:0];
      wdata_in = {2{i_lsu_wdata[15:0]}};
    end else begin
      be_in    = 4'b1111;
      wdata_in = i_lsu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    shifted = i_mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional REQ timeout. The counter is held at 0 outside REQ, so it always
  // starts from 0 on entering REQ. A gnt in the terminal cycle wins.
  // ---------------------------------------------------------------------------
  logic tmo_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == REQ) && !i_mem_gnt &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 tmo_cnt_q <= '0;
    else if (state_q != REQ)   tmo_cnt_q <= '0;
    else if (!i_mem_gnt)       tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps paths that do not
    // assign it from inferring a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_lsu_VALID) state_d = misaligned_in ? RESP : REQ;
      REQ:     if (i_mem_gnt) state_d = WAIT;
               else if (tmo_hit) state_d = RESP;
      WAIT:    if (i_mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;   // VALID here belongs to the retiring request
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
    end else if (state_q == IDLE && i_lsu_VALID) begin
      we_q     <= i_lsu_we;
      funct3_q <= i_lsu_funct3;
      off_q    <= i_lsu_addr[1:0];
      addr_q   <= {i_lsu_addr[31:2], 2'b00};
      be_q     <= be_in;
      wdata_q  <= wdata_in;
    end
  end

  // Response capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_lsu_VALID) begin
          rdata_q      <= 32'h0;
          misaligned_q <= misaligned_in;
          timeout_q    <= 1'b0;
        end
        REQ:  if (tmo_hit) timeout_q <= 1'b1;
        WAIT: if (i_mem_rvalid) rdata_q <= we_q ? 32'h0 : load_ext;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state so reset clears them immediately; response
  // and bus fields are forced to 0 outside their valid windows.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_lsu_READY      = (state_q == RESP);
    o_lsu_rdata      = o_lsu_READY ? rdata_q : 32'h0;
    o_lsu_misaligned = o_lsu_READY & misaligned_q;
    o_lsu_timeout    = o_lsu_READY & timeout_q;
    o_mem_req        = (state_q == REQ);
    o_mem_we         = o_mem_req & we_q;
    o_mem_addr       = o_mem_req ? addr_q : 32'h0;
    o_mem_be         = o_mem_req ? be_q : 4'h0;
    o_mem_wdata      = o_mem_req ? wdata_q : 32'h0;
  end

endmodule

// File: doc/lsu_responder.md
Name: lsu_responder

Overview:
- Load/store unit on the responder side of the MEM-stage LSU VALID/READY handshake.
- The MEM stage holds `i_lsu_VALID` and a stable request until `o_lsu_READY`; the hazard controller stalls the pipeline while VALID & ~READY.
- The block sizes, aligns and byte-enables the access, runs it on a req/gnt/rvalid data-memory bus, and returns aligned, extended load data with a single-cycle READY pulse.

Parameters:
- `TIMEOUT_CYCLES`, 16, cycles in REQ without `i_mem_gnt` before abort (used only with the optional feature).

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  asynchronous active-high reset
- `i_lsu_VALID`  in  1  MEM-stage request valid, held until READY
- `i_lsu_we`  in  1  1 = store, 0 = load
- `i_lsu_funct3`  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `i_lsu_addr`  in  32  byte address
- `i_lsu_wdata`  in  32  store data, right-aligned
- `o_lsu_READY`  out  1  one-cycle completion pulse
- `o_lsu_rdata`  out  32  load result, valid with READY
- `o_lsu_misaligned`  out  1  fault flag, valid with READY
- `o_lsu_timeout`  out  1  fault flag, valid with READY
- `o_mem_req`  out  1  bus request
- `o_mem_we`  out  1  bus write
- `o_mem_addr`  out  32  word address, bits [1:0] = 0
- `o_mem_be`  out  4  byte enables
- `o_mem_wdata`  out  32  lane-shifted store data
- `i_mem_gnt`  in  1  request accepted
- `i_mem_rvalid`  in  1  response (load data or store ack)
- `i_mem_rdata`  in  32  load word

Behaviour:
- Reset: all outputs 0; state IDLE; captured request regs cleared. Reset mid-transaction drops `o_mem_req` immediately and returns to IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, `i_lsu_VALID`=1: capture we/funct3/addr/wdata.
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0): go to RESP with misaligned=1; no bus access.
  - Otherwise go to REQ.
- REQ: `o_mem_req`=1 with registered addr/we/be/wdata, held stable until `i_mem_gnt`; on gnt go to WAIT.
- WAIT: `o_mem_req`=0. On `i_mem_rvalid`, register the load result and go to RESP. `i_mem_rvalid` is ignored in IDLE/REQ/RESP.
- RESP: `o_lsu_READY`=1 for exactly one cycle, flags and rdata valid; then go to IDLE unconditionally.
  - VALID seen during RESP belongs to the retiring request and is ignored.
  - VALID seen in the following IDLE cycle is a new request.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid in first WAIT cycle): VALID sampled at cycle 0 → READY at cycle 3. Misaligned requests: READY at cycle 1.
- Byte enables, with off = addr[1:0]:
  - B: be = 0001 << off.
  - H: be = 0011 << off.
  - W: be = 1111.
- Store lanes:
  - B: wdata[7:0] replicated ×4.
  - H: wdata[15:0] replicated ×2.
  - W: wdata unchanged.
- Load extraction:
  - Shift `i_mem_rdata` right by 8·off.
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
- Stores return rdata = 0.
- funct3 011/110/111 are treated as W (the decoder never issues them).
- Faulted responses have rdata = 0.
- Flags and rdata are 0 whenever READY=0.

Optional Feature:
- `LSU_TIMEOUT_EN`: counter starts at 0 on entering REQ and increments each REQ cycle without gnt.
  - Reaching `TIMEOUT_CYCLES` with no gnt: deassert `o_mem_req` and go to RESP with timeout=1.
  - The bus must not respond to a withdrawn ungranted request.
  - Gnt arriving in the same cycle the count is reached wins; the access proceeds normally.
- Without the macro: no counter; REQ waits indefinitely; `o_lsu_timeout` tied 0.

Test Plan:
- LW addr 0x100, zero-wait memory returning 0xDEADBEEF → `o_mem_be`=1111, `o_mem_addr`=0x100; READY at cycle 3 with rdata 0xDEADBEEF.
- LB addr 0x203, rdata 0x80FF_1234 → be=1000 (read); rdata 0xFFFFFF80. LBU same → 0x00000080.
- SH addr 0x12, wdata 0x0000ABCD → addr 0x10, be=1100, wdata 0xABCDABCD, we=1; READY after rvalid ack; rdata 0.
- LW addr 0x101 → no `o_mem_req` at any time; READY at cycle 1 with misaligned=1.
- Gnt delayed 3 cycles, rvalid delayed 2 more → `o_mem_req` and addr held stable; READY exactly 1 cycle; back-to-back VALID starts the next REQ 2 cycles after READY.
- `LSU_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4, gnt never asserted → `o_mem_req` drops; READY with timeout=1. Assert `i_rst` during WAIT → all outputs 0 immediately; a later rvalid is ignored.
